// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for data-SRAM responses, extracts load data, drops stale responses.
// Optional macro MS_LD_FWD_EN forwards load data to ID in the cycle it returns.
module mem_stage #(
    parameter int CANCEL_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        es_to_ms_valid,
    output logic        ms_allowin,
    input  logic [31:0] es_pc,
    input  logic [31:0] es_result,
    input  logic [4:0]  es_rf_waddr,
    input  logic        es_rf_we,
    input  logic        es_mem_req,
    input  logic        es_ld,
    input  logic [1:0]  es_ld_size,
    input  logic        es_ld_unsigned,
    input  logic        es_csr_re,
    input  logic [86:0] es_ex_zip,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        ms_flush,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_pc,
    output logic [31:0] ms_rf_wdata,
    output logic [4:0]  ms_rf_waddr,
    output logic        ms_rf_we,
    output logic        ms_csr_re,
    output logic [86:0] ms_ex_zip,
    output logic [31:0] ms_result,
    output logic [4:0]  ms_fwd_waddr,
    output logic [31:0] ms_fwd_wdata,
    output logic        ms_fwd_block
);
    localparam logic [CANCEL_W-1:0] CANCEL_MAX = {CANCEL_W{1'b1}};

    logic                ms_valid_r;
    logic [31:0]         ms_pc_r;
    logic [31:0]         ms_result_r;
    logic [4:0]          ms_rf_waddr_r;
    logic                ms_rf_we_r;
    logic                ms_mem_req_r;
    logic                ms_ld_r;
    logic [1:0]          ms_ld_size_r;
    logic                ms_ld_unsigned_r;
    logic                ms_csr_re_r;
    logic [86:0]         ms_ex_zip_r;
    logic                buf_valid_r;
    logic [31:0]         buf_data_r;
    logic [CANCEL_W-1:0] cancel_cnt_r;

    logic                ms_wait_s;
    logic                resp_hit_s;
    logic                stale_s;
    logic                ms_ready_go_s;
    logic                ms_allowin_s;
    logic                ms_to_ws_valid_s;
    logic                handoff_s;
    logic [31:0]         ld_src_s;
    logic [31:0]         byte_shift_s;
    logic [31:0]         half_shift_s;
    logic [31:0]         ld_data_s;
    logic [31:0]         rf_wdata_s;
    logic [1:0]          cancel_inc_s;
    logic [CANCEL_W+1:0] cancel_sum_s;
    logic [CANCEL_W-1:0] cancel_next_s;
    logic                cancel_ovf_s;

    // Handshake, response qualification and pipeline control
    always_comb begin
        resp_hit_s       = data_sram_data_ok & (cancel_cnt_r == {CANCEL_W{1'b0}});
        stale_s          = data_sram_data_ok & (cancel_cnt_r != {CANCEL_W{1'b0}});
        ms_wait_s        = ms_valid_r & ms_mem_req_r & ~buf_valid_r;
        ms_ready_go_s    = ~ms_wait_s | resp_hit_s;
        ms_allowin_s     = ~ms_valid_r | (ms_ready_go_s & ws_allowin);
        ms_to_ws_valid_s = ms_valid_r & ms_ready_go_s & ~ms_flush;
        handoff_s        = ms_to_ws_valid_s & ws_allowin;
    end

    // Load data selection, alignment and extension
    always_comb begin
        ld_src_s     = buf_valid_r ? buf_data_r : data_sram_rdata;
        byte_shift_s = ld_src_s >> {ms_result_r[1:0], 3'b000};
        half_shift_s = ld_src_s >> {ms_result_r[1], 4'b0000};
        case (ms_ld_size_r)
            2'b00:   ld_data_s = ms_ld_unsigned_r ? {24'h000000, byte_shift_s[7:0]}
                                                  : {{24{byte_shift_s[7]}}, byte_shift_s[7:0]};
            2'b01:   ld_data_s = ms_ld_unsigned_r ? {16'h0000, half_shift_s[15:0]}
                                                  : {{16{half_shift_s[15]}}, half_shift_s[15:0]};
            default: ld_data_s = ld_src_s;
        endcase
        if (ms_ld_r) begin
            rf_wdata_s = ld_data_s;
        end else begin
            rf_wdata_s = ms_result_r;
        end
    end

    // Stale-response counter next value; saturates rather than wrapping
    always_comb begin
        if (ms_flush) begin
            cancel_inc_s = {1'b0, ms_wait_s & ~resp_hit_s} + {1'b0, es_to_ms_valid & es_mem_req};
        end else begin
            cancel_inc_s = 2'b00;
        end
        cancel_sum_s = {2'b00, cancel_cnt_r} + {{CANCEL_W{1'b0}}, cancel_inc_s}
                     - {{(CANCEL_W+1){1'b0}}, stale_s};
        if (cancel_sum_s > {2'b00, CANCEL_MAX}) begin
            cancel_ovf_s  = 1'b1;
            cancel_next_s = CANCEL_MAX;
        end else begin
            cancel_ovf_s  = 1'b0;
            cancel_next_s = cancel_sum_s[CANCEL_W-1:0];
        end
    end

    // Valid bit and cancel counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_r   <= 1'b0;
            cancel_cnt_r <= {CANCEL_W{1'b0}};
        end else begin
            cancel_cnt_r <= cancel_next_s;
            if (ms_flush) begin
                ms_valid_r <= 1'b0;
            end else if (ms_allowin_s) begin
                ms_valid_r <= es_to_ms_valid;
            end else begin
                ms_valid_r <= ms_valid_r;
            end
        end
    end

    // Instruction payload from EX
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_pc_r          <= 32'h0000_0000;
            ms_result_r      <= 32'h0000_0000;
            ms_rf_waddr_r    <= 5'd0;
            ms_rf_we_r       <= 1'b0;
            ms_mem_req_r     <= 1'b0;
            ms_ld_r          <= 1'b0;
            ms_ld_size_r     <= 2'b00;
            ms_ld_unsigned_r <= 1'b0;
            ms_csr_re_r      <= 1'b0;
            ms_ex_zip_r      <= 87'd0;
        end else if (es_to_ms_valid & ms_allowin_s) begin
            ms_pc_r          <= es_pc;
            ms_result_r      <= es_result;
            ms_rf_waddr_r    <= es_rf_waddr;
            ms_rf_we_r       <= es_rf_we;
            ms_mem_req_r     <= es_mem_req;
            ms_ld_r          <= es_ld;
            ms_ld_size_r     <= es_ld_size;
            ms_ld_unsigned_r <= es_ld_unsigned;
            ms_csr_re_r      <= es_csr_re;
            ms_ex_zip_r      <= es_ex_zip;
        end else begin
            ms_pc_r          <= ms_pc_r;
        end
    end

    // Holds a response that arrived while WB was stalled
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_valid_r <= 1'b0;
            buf_data_r  <= 32'h0000_0000;
        end else if (ms_flush | handoff_s) begin
            buf_valid_r <= 1'b0;
        end else if (resp_hit_s & ms_wait_s & ~ws_allowin) begin
            buf_valid_r <= 1'b1;
            buf_data_r  <= data_sram_rdata;
        end else begin
            buf_valid_r <= buf_valid_r;
        end
    end

    // Output bundle and forwarding bus
    always_comb begin
        ms_allowin     = resetn & ms_allowin_s;
        ms_to_ws_valid = ms_to_ws_valid_s;
        ms_pc          = ms_pc_r;
        ms_rf_wdata    = rf_wdata_s;
        ms_rf_waddr    = ms_rf_waddr_r;
        ms_rf_we       = ms_valid_r & ms_rf_we_r;
        ms_csr_re      = ms_csr_re_r;
        ms_ex_zip      = ms_ex_zip_r;
        ms_result      = ms_result_r;
        if (ms_valid_r & ms_rf_we_r) begin
            ms_fwd_waddr = ms_rf_waddr_r;
        end else begin
            ms_fwd_waddr = 5'd0;
        end
`ifdef MS_LD_FWD_EN
        ms_fwd_wdata = rf_wdata_s;
        ms_fwd_block = ms_valid_r & ms_ld_r & ms_wait_s & ~resp_hit_s;
`else
        ms_fwd_wdata = ms_result_r;
        ms_fwd_block = ms_valid_r & (ms_ld_r | ms_csr_re_r);
`endif
    end

    mem_stage_chk u_chk (
        .clk        (clk),
        .resetn     (resetn),
        .cancel_ovf (cancel_ovf_s)
    );
endmodule

// Flags more outstanding killed requests than the cancel counter can track.
module mem_stage_chk (
    input logic clk,
    input logic resetn,
    input logic cancel_ovf
);
    a_cancel_no_overflow: assert property (@(posedge clk) disable iff (!resetn) !cancel_ovf);
endmodule
